// File: rtl/bsg_axil_store_unpacker.sv
// Unpacks a 32-bit store/load command into single-byte memory requests and
// returns read bytes (or an all-ones timeout marker) as a 32-bit response.
module bsg_axil_store_unpacker #(
    parameter int unsigned timeout_p = 255
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [31:0] data_i,
    input  logic        v_i,
    output logic        ready_o,
    output logic [31:0] data_o,
    output logic        v_o,
    input  logic        ready_i,
    output logic        mem_v_o,
    output logic        mem_w_o,
    output logic [22:0] mem_addr_o,
    output logic [7:0]  mem_data_o,
    input  logic        mem_ready_i,
    input  logic [7:0]  mem_data_i,
    input  logic        mem_v_i,
    output logic [7:0]  timeout_count_o
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 23;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMER_W = unsigned'($clog2(timeout_p + 1));

    typedef struct packed {
        logic              w;
        logic [ADDR_W-1:0] addr;
        logic [BYTE_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_req  = 2'd1,
        e_wait = 2'd2,
        e_resp = 2'd3
    } state_t;

    state_t             r_state;
    cmd_t               r_cmd;
    logic [DATA_W-1:0]  r_resp;
    logic [TIMER_W-1:0] r_timer;
    logic [CNT_W-1:0]   r_timeout_cnt;

    logic               r_ready;
    logic               r_v;
    logic [DATA_W-1:0]  r_data;
    logic               r_mem_v;
    logic               r_mem_w;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [BYTE_W-1:0]  r_mem_data;

    state_t             w_state_n;
    cmd_t               w_cmd_n;
    logic [DATA_W-1:0]  w_resp_n;
    logic [TIMER_W-1:0] w_timer_n;
    logic [CNT_W-1:0]   w_timeout_cnt_n;

    logic               w_ready_n;
    logic               w_v_n;
    logic [DATA_W-1:0]  w_data_n;
    logic               w_mem_v_n;
    logic               w_mem_w_n;
    logic [ADDR_W-1:0]  w_mem_addr_n;
    logic [BYTE_W-1:0]  w_mem_data_n;

    // State and datapath registers; outputs are registered images of the next state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state       <= e_idle;
            r_cmd         <= '0;
            r_resp        <= '0;
            r_timer       <= '0;
            r_timeout_cnt <= '0;
            r_ready       <= 1'b0;
            r_v           <= 1'b0;
            r_data        <= '0;
            r_mem_v       <= 1'b0;
            r_mem_w       <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data    <= '0;
        end else begin
            r_state       <= w_state_n;
            r_cmd         <= w_cmd_n;
            r_resp        <= w_resp_n;
            r_timer       <= w_timer_n;
            r_timeout_cnt <= w_timeout_cnt_n;
            r_ready       <= w_ready_n;
            r_v           <= w_v_n;
            r_data        <= w_data_n;
            r_mem_v       <= w_mem_v_n;
            r_mem_w       <= w_mem_w_n;
            r_mem_addr    <= w_mem_addr_n;
            r_mem_data    <= w_mem_data_n;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        w_state_n       = r_state;
        w_cmd_n         = r_cmd;
        w_resp_n        = r_resp;
        w_timer_n       = r_timer;
        w_timeout_cnt_n = r_timeout_cnt;

        unique case (r_state)
            e_idle: begin
                // r_ready gates acceptance so the cycle right after reset cannot accept
                if (r_ready && v_i) begin
                    w_cmd_n   = cmd_t'(data_i);
                    w_state_n = e_req;
                end
            end
            e_req: begin
                if (mem_ready_i) begin
                    w_timer_n = '0;
                    w_state_n = r_cmd.w ? e_idle : e_wait;
                end
            end
            e_wait: begin
                if (mem_v_i) begin
                    w_resp_n  = {{(DATA_W-BYTE_W){1'b0}}, mem_data_i};
                    w_state_n = e_resp;
                end else if (r_timer == TIMER_W'(timeout_p - 1)) begin
                    w_resp_n  = '1;
                    w_state_n = e_resp;
                    if (r_timeout_cnt != '1) begin
                        w_timeout_cnt_n = r_timeout_cnt + CNT_W'(1);
                    end
                end else begin
                    w_timer_n = r_timer + TIMER_W'(1);
                end
            end
            e_resp: begin
                if (ready_i) begin
                    w_state_n = e_idle;
                end
            end
            default: begin
                w_state_n = e_idle;
            end
        endcase

        w_ready_n    = (w_state_n == e_idle);
        w_mem_v_n    = (w_state_n == e_req);
        w_mem_w_n    = w_mem_v_n && w_cmd_n.w;
        w_mem_addr_n = w_mem_v_n ? w_cmd_n.addr : '0;
        w_mem_data_n = w_mem_w_n ? w_cmd_n.wdata : '0;
        w_v_n        = (w_state_n == e_resp);
        w_data_n     = w_v_n ? w_resp_n : '0;
    end

    assign ready_o         = r_ready;
    assign v_o             = r_v;
    assign data_o          = r_data;
    assign mem_v_o         = r_mem_v;
    assign mem_w_o         = r_mem_w;
    assign mem_addr_o      = r_mem_addr;
    assign mem_data_o      = r_mem_data;
    assign timeout_count_o = r_timeout_cnt;

endmodule

// File: tb/tb_bsg_axil_store_unpacker.sv
// Directed bench for bsg_axil_store_unpacker: vector table plus hand-written
// backpressure, timeout, saturation and reset sequences.
module tb_bsg_axil_store_unpacker;

    logic        clk;
    logic        reset_n_i;
    logic [31:0] data_i;
    logic        v_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic        v_o;
    logic        ready_i;
    logic        mem_v_o;
    logic        mem_w_o;
    logic [22:0] mem_addr_o;
    logic [7:0]  mem_data_o;
    logic        mem_ready_i;
    logic [7:0]  mem_data_i;
    logic        mem_v_i;
    logic [7:0]  timeout_count_o;

    int n_checks = 0;
    int n_fails  = 0;

    bsg_axil_store_unpacker #(.timeout_p(4)) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n_i),
        .data_i         (data_i),
        .v_i            (v_i),
        .ready_o        (ready_o),
        .data_o         (data_o),
        .v_o            (v_o),
        .ready_i        (ready_i),
        .mem_v_o        (mem_v_o),
        .mem_w_o        (mem_w_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_ready_i    (mem_ready_i),
        .mem_data_i     (mem_data_i),
        .mem_v_i        (mem_v_i),
        .timeout_count_o(timeout_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] din;
        logic        mrdy;
        logic        mv;
        logic [7:0]  mdin;
        logic        rdy;
        logic [74:0] exp;
    } vec_t;

    vec_t vecs[15];

    // {ready_o, v_o, data_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, timeout_count_o}
    function automatic logic [74:0] pk(input logic r, input logic v, input logic [31:0] d,
                                       input logic mv, input logic mw, input logic [22:0] a,
                                       input logic [7:0] md, input logic [7:0] tc);
        return {r, v, d, mv, mw, a, md, tc};
    endfunction

    function automatic logic [74:0] snap();
        return {ready_o, v_o, data_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, timeout_count_o};
    endfunction

    function automatic vec_t mk(input logic v, input logic [31:0] din, input logic mrdy,
                                input logic mv, input logic [7:0] mdin, input logic rdy,
                                input logic [74:0] exp);
        vec_t t;
        t.v = v; t.din = din; t.mrdy = mrdy; t.mv = mv; t.mdin = mdin; t.rdy = rdy; t.exp = exp;
        return t;
    endfunction

    task automatic check(input string name, input logic [74:0] act, input logic [74:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        v_i = 1'b0; data_i = '0; mem_ready_i = 1'b0; mem_v_i = 1'b0; mem_data_i = '0; ready_i = 1'b1;
    endtask

    // Issue a read that never gets a byte back; lat = cycles from wait entry to v_o.
    task automatic timeout_read(output int lat);
        v_i = 1'b1; data_i = 32'h0000_4400; mem_ready_i = 1'b1; mem_v_i = 1'b0;
        @(negedge clk); v_i = 1'b0;
        @(negedge clk); mem_ready_i = 1'b0;
        lat = 0;
        while (!v_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
    endtask

    localparam logic [74:0] IDLE0 = 75'h400_0000_0000_0000_0000;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int acc;
        int pulses;
        int bad;
        logic [74:0] held;

        vecs[0]  = mk(1, 32'h8000_12A5, 1, 0, 8'h00, 1, pk(0,0,32'h0,       1,1,23'h000012,8'hA5,8'd0));
        vecs[1]  = mk(0, 32'h0,         1, 0, 8'h00, 1, pk(1,0,32'h0,       0,0,23'h0,     8'h00,8'd0));
        vecs[2]  = mk(1, 32'h0001_2300, 0, 0, 8'h00, 1, pk(0,0,32'h0,       1,0,23'h000123,8'h00,8'd0));
        vecs[3]  = mk(0, 32'h0,         1, 0, 8'h00, 1, pk(0,0,32'h0,       0,0,23'h0,     8'h00,8'd0));
        vecs[4]  = mk(0, 32'h0,         0, 1, 8'h5C, 1, pk(0,1,32'h0000_005C,0,0,23'h0,    8'h00,8'd0));
        vecs[5]  = mk(0, 32'h0,         0, 1, 8'h77, 0, pk(0,1,32'h0000_005C,0,0,23'h0,    8'h00,8'd0));
        vecs[6]  = mk(0, 32'h0,         0, 0, 8'h00, 1, pk(1,0,32'h0,       0,0,23'h0,     8'h00,8'd0));
        vecs[7]  = mk(1, 32'h7FFF_FF33, 0, 0, 8'h00, 1, pk(0,0,32'h0,       1,0,23'h7FFFFF,8'h00,8'd0));
        vecs[8]  = mk(0, 32'h0,         1, 1, 8'h11, 1, pk(0,0,32'h0,       0,0,23'h0,     8'h00,8'd0));
        vecs[9]  = mk(0, 32'h0,         0, 1, 8'hFF, 1, pk(0,1,32'h0000_00FF,0,0,23'h0,    8'h00,8'd0));
        vecs[10] = mk(1, 32'h8000_0042, 0, 0, 8'h00, 1, pk(1,0,32'h0,       0,0,23'h0,     8'h00,8'd0));
        vecs[11] = mk(1, 32'hFFFF_FFFF, 0, 0, 8'h00, 1, pk(0,0,32'h0,       1,1,23'h7FFFFF,8'hFF,8'd0));
        vecs[12] = mk(0, 32'h0,         1, 0, 8'h00, 1, pk(1,0,32'h0,       0,0,23'h0,     8'h00,8'd0));
        vecs[13] = mk(1, 32'h8000_0000, 0, 0, 8'h00, 1, pk(0,0,32'h0,       1,1,23'h0,     8'h00,8'd0));
        vecs[14] = mk(0, 32'h0,         1, 0, 8'h00, 1, pk(1,0,32'h0,       0,0,23'h0,     8'h00,8'd0));

        reset_n_i = 1'b0;
        idle_inputs();
        #12;
        check("reset_outputs", snap(), '0);
        @(negedge clk);
        reset_n_i = 1'b1;
        check("reset_release_same_cycle", snap(), '0);
        @(negedge clk);
        check("ready_after_reset", snap(), IDLE0);

        // Vector table: drive at a falling edge, compare after the next rising edge.
        for (int i = 0; i < 15; i++) begin
            v_i = vecs[i].v; data_i = vecs[i].din; mem_ready_i = vecs[i].mrdy;
            mem_v_i = vecs[i].mv; mem_data_i = vecs[i].mdin; ready_i = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d", i), snap(), vecs[i].exp);
        end
        idle_inputs();

        // Back-to-back writes with memory always ready: one accept per two cycles.
        v_i = 1'b1; data_i = 32'h8000_0101; mem_ready_i = 1'b1;
        acc = 0; pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (ready_o && v_i) acc++;
            if (mem_v_o) pulses++;
            @(negedge clk);
        end
        v_i = 1'b0;
        check("write_accepts", 75'(acc), 75'(4));
        check("write_pulses", 75'(pulses), 75'(4));
        check("write_stream_idle", snap(), IDLE0);

        // Memory stalls 5 cycles, then response stalls.
        v_i = 1'b1; data_i = 32'h0001_2300; mem_ready_i = 1'b0;
        @(negedge clk);
        v_i = 1'b0;
        held = pk(0,0,32'h0,1,0,23'h000123,8'h00,8'd0);
        check("bp_req_c1", snap(), held);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_req_c%0d", k + 2), snap(), held);
        end
        mem_ready_i = 1'b1;
        @(negedge clk);
        mem_ready_i = 1'b0; mem_v_i = 1'b1; mem_data_i = 8'hA7; ready_i = 1'b0;
        @(negedge clk);
        mem_v_i = 1'b0;
        held = pk(0,1,32'h0000_00A7,0,0,23'h0,8'h00,8'd0);
        check("bp_resp_c1", snap(), held);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("bp_resp_c%0d", k + 2), snap(), held);
        end
        ready_i = 1'b1;
        @(negedge clk);
        check("bp_done", snap(), IDLE0);

        // Timeout exactly four cycles after wait entry.
        timeout_read(lat);
        check("timeout_latency", 75'(lat), 75'(4));
        check("timeout_idle", snap(), pk(1,0,32'h0,0,0,23'h0,8'h00,8'd1));

        v_i = 1'b1; data_i = 32'h0000_4400; mem_ready_i = 1'b1;
        @(negedge clk);
        v_i = 1'b0;
        @(negedge clk);
        mem_ready_i = 1'b0;
        check("timeout_data_wait", snap(), pk(0,0,32'h0,0,0,23'h0,8'h00,8'd1));
        repeat (3) @(negedge clk);
        mem_v_i = 1'b1; mem_data_i = 8'h3C;
        @(negedge clk);
        mem_v_i = 1'b0;
        check("data_beats_timeout", snap(), pk(0,1,32'h0000_003C,0,0,23'h0,8'h00,8'd1));
        @(negedge clk);

        // Full timeout response value.
        v_i = 1'b1; data_i = 32'h0000_4400; mem_ready_i = 1'b1;
        @(negedge clk);
        v_i = 1'b0;
        @(negedge clk);
        mem_ready_i = 1'b0;
        repeat (4) @(negedge clk);
        check("timeout_resp", snap(), pk(0,1,32'hFFFF_FFFF,0,0,23'h0,8'h00,8'd2));
        @(negedge clk);

        // Saturation of the timeout counter.
        bad = 0;
        for (int k = 0; k < 252; k++) begin
            timeout_read(lat);
            if (lat != 4) bad++;
        end
        check("count_254", 75'(timeout_count_o), 75'(254));
        for (int k = 0; k < 47; k++) begin
            timeout_read(lat);
            if (lat != 4) bad++;
        end
        check("count_saturated", 75'(timeout_count_o), 75'(255));
        check("sat_latencies", 75'(bad), 75'(0));

        // Reset while waiting for a read byte; late byte must be ignored.
        v_i = 1'b1; data_i = 32'h0000_5500; mem_ready_i = 1'b1;
        @(negedge clk);
        v_i = 1'b0;
        @(negedge clk);
        mem_ready_i = 1'b0;
        @(negedge clk);
        #2 reset_n_i = 1'b0;
        #1 check("async_reset", snap(), '0);
        @(negedge clk);
        check("held_reset", snap(), '0);
        reset_n_i = 1'b1; mem_v_i = 1'b1; mem_data_i = 8'h99;
        @(negedge clk);
        mem_v_i = 1'b0;
        check("post_reset_idle", snap(), IDLE0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("post_reset_c%0d", k), snap(), IDLE0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
